tt_um_restoring_divider4: RTL and testbench

Sequential 4-bit unsigned restoring divider for the TinyTapeout tile; the inverse-operation companion to the team's 4-bit prefix adder. Takes dividend and divisor on `ui_in`, runs one shift/trial-subtract step per clock, and presents registered quotient and remainder on `uo_out` with busy/done/divide-by-zero status on `uio_out`. The trial subtraction is built on the same Kogge-Stone prefix carry network as the adder.

---
 rtl/divider4_pkg.sv | 23 ++
 rtl/kogge_stone_sub5.sv | 55 +++++
 rtl/tt_um_restoring_divider4.sv | 145 ++++++++++++++
 tb/tb_tt_um_restoring_divider4.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/divider4_pkg.sv
// Shared definitions for the 4-bit restoring divider tile.
//   state_e  : FSM encoding (idle / iterating / result held)
//   N        : operand, quotient and remainder width
//   *Bit     : status bit positions within uio_out
//   UioOe    : constant output-enable pattern for the bidirectional pins
package divider4_pkg;

  localparam int unsigned N    = 4;
  localparam int unsigned CntW = $clog2(N);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned BusyBit = 1;
  localparam int unsigned DoneBit = 2;
  localparam int unsigned DbzBit  = 3;

  localparam logic [7:0] UioOe = 8'b0000_1110;

endpackage

// File: rtl/kogge_stone_sub5.sv
// 5-bit subtractor built on a Kogge-Stone prefix carry network.
//   a, b   : minuend and subtrahend
//   diff   : a - b (mod 32)
//   borrow : 1 when b > a
// Computes a + ~b + 1; the +1 is a carry-in folded into the final carry step.
module kogge_stone_sub5 (
  input  logic [4:0] a,
  input  logic [4:0] b,
  output logic [4:0] diff,
  output logic       borrow
);

  logic [4:0] g0, p0, g1, p1, g2, p2, g3, p3;
  logic [5:0] carry;

  assign g0 = a & ~b;
  assign p0 = a ^ ~b;

  // Prefix stages at distances 1, 2, 4: after stage 3, (g3[i], p3[i]) spans bits [i:0].
  for (genvar i = 0; i < 5; i++) begin : gen_s1
    if (i >= 1) begin : gen_merge
      assign g1[i] = g0[i] | (p0[i] & g0[i-1]);
      assign p1[i] = p0[i] & p0[i-1];
    end else begin : gen_pass
      assign g1[i] = g0[i];
      assign p1[i] = p0[i];
    end
  end

  for (genvar i = 0; i < 5; i++) begin : gen_s2
    if (i >= 2) begin : gen_merge
      assign g2[i] = g1[i] | (p1[i] & g1[i-2]);
      assign p2[i] = p1[i] & p1[i-2];
    end else begin : gen_pass
      assign g2[i] = g1[i];
      assign p2[i] = p1[i];
    end
  end

  for (genvar i = 0; i < 5; i++) begin : gen_s3
    if (i >= 4) begin : gen_merge
      assign g3[i] = g2[i] | (p2[i] & g2[i-4]);
      assign p3[i] = p2[i] & p2[i-4];
    end else begin : gen_pass
      assign g3[i] = g2[i];
      assign p3[i] = p2[i];
    end
  end

  // Carry-in is 1, so carry into bit i+1 is G[i:0] | P[i:0].
  assign carry  = {g3 | p3, 1'b1};
  assign diff   = p0 ^ carry[4:0];
  assign borrow = ~carry[5];

endmodule

// File: rtl/tt_um_restoring_divider4.sv
// Sequential 4-bit unsigned restoring divider, one trial subtraction per clock.
//   clk, rst : clock and synchronous active-high reset
//   ui_in    : [3:0] dividend, [7:4] divisor
//   uio_in   : [0] start (level)
//   ena      : unused
//   uo_out   : [3:0] quotient, [7:4] remainder, registered on completion
//   uio_out  : [1] busy, [2] done, [3] divide-by-zero
//   uio_oe   : constant enable for the status pins
module tt_um_restoring_divider4
  import divider4_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  input  logic       ena,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_e          state_q, state_d;
  logic [N-1:0]    dvd_q, dvd_d;
  logic [N-1:0]    dvs_q, dvs_d;
  logic [N:0]      rem_q, rem_d;
  logic [N-1:0]    q_q, q_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      res_q, res_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            dbz_q, dbz_d;

  logic            start;
  logic [N:0]      trial, diff, rem_next;
  logic [N-1:0]    q_next;
  logic            borrow;
  logic            unused;

  assign start  = uio_in[0];
  assign unused = ^{ena, uio_in[7:1]};

  // Shift the next dividend bit into the partial remainder, then try subtracting.
  assign trial = {rem_q[N-1:0], dvd_q[N-1]};

  kogge_stone_sub5 u_sub (
    .a      (trial),
    .b      ({1'b0, dvs_q}),
    .diff   (diff),
    .borrow (borrow)
  );

  assign rem_next = borrow ? trial : diff;
  assign q_next   = {q_q[N-2:0], ~borrow};

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    busy_d  = busy_q;
    done_d  = done_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          dvd_d = ui_in[N-1:0];
          dvs_d = ui_in[2*N-1:N];
          rem_d = '0;
          q_d   = '0;
          cnt_d = '0;
          if (ui_in[2*N-1:N] != '0) begin
            busy_d  = 1'b1;
            state_d = StRun;
          end else begin
            res_d   = {ui_in[N-1:0], {N{1'b1}}};
            done_d  = 1'b1;
            dbz_d   = 1'b1;
            state_d = StDone;
          end
        end
      end
      StRun: begin
        dvd_d = dvd_q << 1;
        rem_d = rem_next;
        q_d   = q_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(N - 1)) begin
          res_d   = {rem_next[N-1:0], q_next};
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        // Requires start to drop before another capture, so a held start cannot retrigger.
        if (!start) begin
          done_d  = 1'b0;
          dbz_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    uio_out          = '0;
    uio_out[BusyBit] = busy_q;
    uio_out[DoneBit] = done_q;
    uio_out[DbzBit]  = dbz_q;
  end

  assign uo_out = res_q;
  assign uio_oe = UioOe;

endmodule

// File: tb/tb_tt_um_restoring_divider4.sv
module tb_tt_um_restoring_divider4;

  logic       clk;
  logic       rst;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic       ena;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks;
  int errors;

  logic [7:0] exp_q[$];

  tt_um_restoring_divider4 dut (
    .clk     (clk),
    .rst     (rst),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .ena     (ena),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire busy = uio_out[1];
  wire done = uio_out[2];
  wire dbz  = uio_out[3];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model(input logic [3:0] dd, input logic [3:0] ds);
    logic [3:0] qq;
    logic [3:0] rr;
    if (ds == 4'd0) return {dd, 4'hF};
    qq = dd / ds;
    rr = dd % ds;
    return {rr, qq};
  endfunction

  // One division at minimum spacing: capture, 4 iterations, one DONE cycle with start low.
  task automatic run_div(input logic [3:0] dd, input logic [3:0] ds, input string name);
    logic [7:0] e;
    exp_q.push_back(model(dd, ds));
    ui_in  = {ds, dd};
    uio_in = 8'h01;
    step();
    uio_in = 8'h00;
    ui_in  = 8'($urandom);  // operands after capture must not matter
    if (ds == 4'd0) begin
      checks++;
      if (done !== 1'b1 || dbz !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s dbz status: got busy=%b done=%b dbz=%b want 0 1 1", name, busy, done, dbz);
      end
    end else begin
      for (int k = 1; k <= 4; k++) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL %s busy cycle %0d: got busy=%b done=%b want 1 0", name, k, busy, done);
        end
        step();
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || dbz !== 1'b0) begin
        errors++;
        $display("FAIL %s completion: got busy=%b done=%b dbz=%b want 0 1 0", name, busy, done, dbz);
      end
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      if (uo_out !== e) begin
        errors++;
        $display("FAIL %s result: got uo_out=%02h want %02h", name, uo_out, e);
      end
    end
    step();
    checks++;
    if (uio_out !== 8'h00 || uo_out !== model(dd, ds)) begin
      errors++;
      $display("FAIL %s after drop: got uio_out=%02h uo_out=%02h want 00 %02h",
               name, uio_out, uo_out, model(dd, ds));
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    ena    = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
      errors++;
      $display("FAIL reset outputs: got uo_out=%02h uio_out=%02h want 00 00", uo_out, uio_out);
    end
    checks++;
    if (uio_oe !== 8'h0E) begin
      errors++;
      $display("FAIL uio_oe: got %02h want 0e", uio_oe);
    end
  endtask

  task automatic test_basic();
    run_div(4'd13, 4'd3, "13div3");
    checks++;
    if (uo_out !== 8'h14) begin
      errors++;
      $display("FAIL 13div3 const: got %02h want 14", uo_out);
    end
    run_div(4'd15, 4'd1, "15div1");
    checks++;
    if (uo_out !== 8'h0F) begin
      errors++;
      $display("FAIL 15div1 const: got %02h want 0f", uo_out);
    end
    run_div(4'd5, 4'd7, "5div7");
    checks++;
    if (uo_out !== 8'h50) begin
      errors++;
      $display("FAIL 5div7 const: got %02h want 50", uo_out);
    end
  endtask

  task automatic test_dbz();
    run_div(4'd9, 4'd0, "9div0");
    checks++;
    if (uo_out !== 8'h9F) begin
      errors++;
      $display("FAIL 9div0 const: got %02h want 9f", uo_out);
    end
  endtask

  task automatic test_start_held();
    int completions;
    logic prev_done;
    logic [7:0] e;
    completions = 0;
    prev_done   = done;
    exp_q.push_back(8'h14);
    ui_in  = 8'h3D;
    uio_in = 8'h01;
    for (int c = 0; c < 20; c++) begin
      step();
      if (done && !prev_done) begin
        completions++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL held scoreboard empty");
        end else begin
          e = exp_q.pop_front();
          if (uo_out !== e) begin
            errors++;
            $display("FAIL held result: got %02h want %02h", uo_out, e);
          end
        end
      end
      if (completions > 0) begin
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL held hold cycle %0d: got busy=%b done=%b want 0 1", c, busy, done);
        end
      end
      prev_done = done;
    end
    checks++;
    if (completions != 1) begin
      errors++;
      $display("FAIL held completions: got %0d want 1", completions);
    end
    uio_in = 8'h00;
    step();
    checks++;
    if (uio_out !== 8'h00) begin
      errors++;
      $display("FAIL held drop: got uio_out=%02h want 00", uio_out);
    end
  endtask

  task automatic test_reset_mid_run();
    ui_in  = 8'h3D;
    uio_in = 8'h01;
    step();              // capture
    uio_in = 8'h00;
    step();              // first RUN cycle
    rst = 1'b1;
    step();              // reset lands on the second RUN cycle
    rst = 1'b0;
    checks++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
      errors++;
      $display("FAIL mid-run reset: got uo_out=%02h uio_out=%02h want 00 00", uo_out, uio_out);
    end
    step();
    checks++;
    if (uio_out !== 8'h00) begin
      errors++;
      $display("FAIL post-reset idle: got uio_out=%02h want 00", uio_out);
    end
    run_div(4'd13, 4'd3, "rerun13div3");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] pair;
      pair = 8'(i);
      run_div(pair[3:0], pair[7:4], "exhaustive");
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_dbz();
    test_start_held();
    test_reset_mid_run();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover: got %0d entries want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
